// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the synchronous FIFO family.
// Pointers carry one extra wrap bit above the storage address.
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 16;

    // Address bits plus the wrap bit that separates full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: one synchronous write port, one asynchronous read port.
// Contents are never cleared; occupancy tracking lives in the controller.
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch on purpose; readers only ever see
    // entries that were written since the last reset or flush, so clearing it
    // would cost a reset net per bit and buy nothing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy flags and sticky overflow/underflow.
// All status is decoded from the registered pointers, never from the request inputs.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        rd_en,
    output logic [WIDTH-1:0]            rd_data,
    input  logic                        flush,
    input  logic                        clr_err,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [ptr_width(DEPTH)-1:0] count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             wr_accept;
    logic             rd_accept;
    logic [WIDTH-1:0] mem_rd_data;

    // Pointers wrap modulo 2*DEPTH, so the plain difference is the occupancy.
    assign count        = wptr - rptr;
    assign full         = (count == PW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= PW'(AF_LEVEL));
    assign almost_empty = (count <= PW'(AE_LEVEL));

    // Acceptance uses the pre-edge full/empty, so a pop never makes room for a
    // same-cycle push and a push never feeds a same-cycle pop.
    assign wr_accept = wr_en && !full && !flush && !rst;
    assign rd_accept = rd_en && !empty && !flush;

    // NOTE: every register here is updated with <= so that all of them sample
    // the same pre-edge values; a blocking = would let later statements see
    // already-updated pointers and break the simultaneous read/write case.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_accept) begin
                wptr <= wptr + PW'(1);
            end
            if (rd_accept) begin
                rptr <= rptr + PW'(1);
            end
        end
    end

    // A setting condition in the same cycle as clr_err wins, so no event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  && !clr_err) || (wr_en && full  && !flush);
            underflow <= (underflow && !clr_err) || (rd_en && empty && !flush);
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wptr[AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (rptr[AW-1:0]),
        .rd_data (mem_rd_data)
    );

    assign rd_data = empty ? '0 : mem_rd_data;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the FIFO's behaviour.
module tb_sync_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             flush;
    logic             clr_err;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    int errors = 0;
    int checks = 0;

    // Reference model: the FIFO contents as a queue, plus the two sticky flags.
    logic [WIDTH-1:0] model_q [$];
    bit               model_ov;
    bit               model_un;

    always #5 clk = ~clk;

    sync_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .flush        (flush),
        .clr_err      (clr_err),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ".count"},        64'(count),        64'(sz));
        check({tag, ".full"},         64'(full),         64'(sz == DEPTH));
        check({tag, ".empty"},        64'(empty),        64'(sz == 0));
        check({tag, ".almost_full"},  64'(almost_full),  64'(sz >= AF));
        check({tag, ".almost_empty"}, 64'(almost_empty), 64'(sz <= AE));
        check({tag, ".overflow"},     64'(overflow),     64'(model_ov));
        check({tag, ".underflow"},    64'(underflow),    64'(model_un));
        check({tag, ".rd_data"},      64'(rd_data),      (sz > 0) ? 64'(model_q[0]) : 64'd0);
    endtask

    // One clock: drive inputs, advance the model across the edge, check outputs #1 later.
    task automatic step(input string tag, input logic w, input logic [WIDTH-1:0] d,
                        input logic r, input logic f, input logic c, input logic rs);
        bit was_full;
        bit was_empty;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        clr_err = c;
        rst     = rs;
        @(posedge clk);
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        if (rs) begin
            model_q.delete();
            model_ov = 1'b0;
            model_un = 1'b0;
        end else begin
            if (f) begin
                model_q.delete();
            end else begin
                if (r && !was_empty) void'(model_q.pop_front());
                if (w && !was_full) model_q.push_back(d);
            end
            model_ov = (model_ov && !c) || (w && was_full && !f);
            model_un = (model_un && !c) || (r && was_empty && !f);
        end
        #1;
        check_all(tag);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        logic             w;
        logic             r;
        logic             f;
        logic             c;

        rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;

        step("reset0", 0, 0, 0, 0, 0, 1);
        step("reset1", 0, 0, 0, 0, 0, 1);
        check("reset.count", 64'(count), 64'd0);
        check("reset.almost_empty", 64'(almost_empty), 64'd1);

        // Fill with 0x1..0x10; almost_full must appear exactly at count 14.
        for (int i = 1; i <= DEPTH; i++) begin
            step("fill", 1, WIDTH'(i), 0, 0, 0, 0);
            if (i == AF - 1) check("af_below", 64'(almost_full), 64'd0);
            if (i == AF)     check("af_at_level", 64'(almost_full), 64'd1);
        end
        check("full16", 64'(full), 64'd1);
        check("count16", 64'(count), 64'd16);

        // Write while full is dropped and latches overflow until clr_err.
        step("ovf_write", 1, 32'hDEAD, 0, 0, 0, 0);
        check("ovf_sticky_set", 64'(overflow), 64'd1);
        step("ovf_hold", 0, 0, 0, 0, 0, 0);
        step("ovf_clear", 0, 0, 0, 0, 1, 0);
        check("ovf_cleared", 64'(overflow), 64'd0);

        // Drain: words come back 0x1..0x10 with no trace of 0xDEAD.
        for (int i = 1; i <= DEPTH; i++) begin
            check("drain_head", 64'(rd_data), 64'(i));
            step("drain", 0, 0, 1, 0, 0, 0);
        end
        check("drained_empty", 64'(empty), 64'd1);

        // Read+write on empty: read rejected (underflow), write accepted.
        step("unf_rdwr", 1, 32'hA5, 1, 0, 0, 0);
        check("unf_set", 64'(underflow), 64'd1);
        check("unf_head", 64'(rd_data), 64'hA5);
        step("unf_clear", 0, 0, 0, 0, 1, 0);

        // Bring occupancy to 8, then 40 cycles of simultaneous push/pop.
        for (int i = 0; i < 7; i++) step("to8", 1, $urandom, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) step("steady8", 1, $urandom, 1, 0, 0, 0);
        check("steady_count", 64'(count), 64'd8);

        // Down to 5, then flush beats a concurrent write.
        for (int i = 0; i < 3; i++) step("to5", 0, 0, 1, 0, 0, 0);
        step("flush", 1, 32'h1234, 0, 1, 0, 0);
        check("flush_empty", 64'(empty), 64'd1);
        check("flush_rd_data", 64'(rd_data), 64'd0);

        // Randomised traffic with occasional flush and clr_err.
        for (int i = 0; i < 400; i++) begin
            w = 1'($urandom_range(0, 3) != 0);
            r = 1'($urandom_range(0, 2) != 0);
            f = 1'($urandom_range(0, 40) == 0);
            c = 1'($urandom_range(0, 15) == 0);
            d = $urandom;
            step("random", w, d, r, f, c, 0);
        end

        // Reset in the middle of a write burst throws everything away.
        for (int i = 0; i < 6; i++) step("burst", 1, $urandom, 0, 0, 0, 0);
        step("burst_rst", 1, 32'hBEEF, 0, 0, 0, 1);
        check("rst.count", 64'(count), 64'd0);
        check("rst.empty", 64'(empty), 64'd1);
        check("rst.full", 64'(full), 64'd0);
        check("rst.rd_data", 64'(rd_data), 64'd0);
        check("rst.overflow", 64'(overflow), 64'd0);
        check("rst.underflow", 64'(underflow), 64'd0);
        step("post_rst", 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, >=2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold (1..DEPTH).
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold (0..DEPTH-1).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port wr_en  input  1  write request.
REQ-008 SHALL have port wr_data  input  WIDTH  write word.
REQ-009 SHALL have port rd_en  input  1  read (pop) request.
REQ-010 SHALL have port rd_data  output  WIDTH  head word, show-ahead.
REQ-011 SHALL have port flush  input  1  discard all contents.
REQ-012 SHALL have port clr_err  input  1  clear sticky error flags.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL use read/write pointers of $clog2(DEPTH)+1 bits; low bits address storage, MSB is wrap bit; pointers wrap modulo 2*DEPTH.
REQ-017 SHALL accept a write (store wr_data at wptr, wptr+1) iff wr_en && !full && !flush.
REQ-018 SHALL accept a read (rptr+1) iff rd_en && !empty && !flush.
REQ-019 SHALL evaluate full/empty on pre-edge state: write while full is rejected even with a simultaneous accepted read; read while empty is rejected even with a simultaneous write.
REQ-020 SHALL keep count unchanged on simultaneous accepted write and read; otherwise +1/-1 per accepted write/read.
REQ-021 SHALL drive count = wptr - rptr, full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL); all decoded from registered pointers only, no input-to-flag combinational path.
REQ-022 SHALL present rd_data = storage[rptr] combinationally when !empty, and all-zeros when empty.
REQ-023 SHALL make a written word visible on rd_data one cycle after the accepting edge (empty deasserts same cycle).
REQ-024 SHALL on flush set rptr=wptr=0 at the next edge; flush dominates wr_en/rd_en that cycle; storage contents not cleared.
REQ-025 SHALL set overflow on any edge with wr_en && full (flush low); set underflow on any edge with rd_en && empty (flush low).
REQ-026 SHALL hold overflow/underflow until clr_err or rst; setting condition coincident with clr_err leaves flag set.
REQ-027 SHALL not alter error flags on flush.

Reset
REQ-028 SHALL on rst at clock edge: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, rd_data 0.
REQ-029 SHALL give rst priority over flush, clr_err, wr_en, rd_en; reset mid-burst discards all entries.
REQ-030 SHALL not reset storage array.

Structure
REQ-031 SHALL take default WIDTH/DEPTH and pointer-width function from shared package fifo_pkg.
REQ-032 SHALL place storage in sub-module sync_fifo_mem (one synchronous write port, one asynchronous read port).

Verification
REQ-033 SHALL cover: DEPTH=16, WIDTH=32, rst, write 0x1..0x10 -> full=1 after 16th edge, count=16, almost_full asserted at count 14; reads return 0x1..0x10 in order, empty=1 after last.
REQ-034 SHALL cover: full FIFO, wr_en with data 0xDEAD -> rejected, overflow=1 sticky, contents unchanged; clr_err -> overflow=0 next cycle.
REQ-035 SHALL cover: empty, rd_en=1 and wr_en=1 with 0xA5 same cycle -> underflow=1, count=1, rd_data=0xA5 next cycle.
REQ-036 SHALL cover: count=8, simultaneous read and write for 40 cycles -> count stays 8, pointers wrap, data order preserved.
REQ-037 SHALL cover: count=5, flush with wr_en=1 -> count=0, empty=1, rd_data=0 next cycle; then rst mid-write burst -> all outputs at REQ-028 values.
